// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the buffer-SRAM port arbiter.
package sram_arb_pkg;

    typedef enum logic {
        ARB,
        LOCKED
    } arb_state_e;

    localparam int unsigned N_REQ_DEF = 3;
    localparam int unsigned AW_DEF    = 8;
    localparam int unsigned DW_DEF    = 32;
    localparam int unsigned IDX_W     = $clog2(N_REQ_DEF);

    typedef struct packed {
        logic              we;
        logic [AW_DEF-1:0] addr;
        logic [DW_DEF-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request at or above the pointer, wrapping to 0.
module rr_arbiter #(
    parameter  int unsigned N  = 3,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        int unsigned j;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int unsigned i = 0; i < N; i++) begin
            j = 32'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!any && req[j[IW-1:0]]) begin
                any              = 1'b1;
                gnt[j[IW-1:0]]   = 1'b1;
                idx              = j[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter with burst lock sharing one single-port SRAM among N_REQ masters;
// registered memory-side outputs and read data returned to the granted requester two cycles later.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter  int unsigned N_REQ = 3,
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned COL   = 4,
    parameter  int unsigned SIZE  = 256,
    parameter  int unsigned CNT_W = 16,
    localparam int unsigned AW    = $clog2(SIZE),
    localparam int unsigned DW    = COL * WIDTH,
    localparam int unsigned IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ-1:0]       lock_i,
    input  logic [N_REQ-1:0]       we_i,
    input  logic [N_REQ*AW-1:0]    addr_i,
    input  logic [N_REQ*DW-1:0]    wdata_i,
    output logic [N_REQ-1:0]       gnt_o,
    output logic [N_REQ-1:0]       rvalid_o,
    output logic [DW-1:0]          rdata_o,
    output logic [N_REQ*CNT_W-1:0] stall_cnt_o,
    output logic                   mem_cenb_o,
    output logic                   mem_wenb_o,
    output logic [AW-1:0]          mem_addr_o,
    output logic [DW-1:0]          mem_data_o,
    input  logic [DW-1:0]          mem_data_i
);

    arb_state_e       state, state_n;
    logic [IW-1:0]    ptr, ptr_n;
    logic [IW-1:0]    owner, owner_n;
    logic [IW-1:0]    win;
    logic [N_REQ-1:0] elig, gnt, rv_n;
    logic             any, granted;
    logic             rd_pend;
    logic [IW-1:0]    rd_idx;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] v);
        if (32'(v) == N_REQ - 1) begin
            return '0;
        end
        return v + 1'b1;
    endfunction

    for (genvar k = 0; k < N_REQ; k++) begin : g_req
        logic [CNT_W-1:0] cnt;

        // While locked, only the owner is eligible for the arbiter.
        assign elig[k] = req_i[k] & ((state == ARB) | (owner == IW'(k)));
        assign rv_n[k] = rd_pend & (rd_idx == IW'(k));
        assign stall_cnt_o[k*CNT_W +: CNT_W] = cnt;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                cnt <= '0;
            end else if (req_i[k] && !gnt_o[k] && !(&cnt)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    rr_arbiter #(
        .N(N_REQ)
    ) u_rr (
        .req(elig),
        .ptr(ptr),
        .gnt(gnt),
        .idx(win),
        .any(any)
    );

    assign gnt_o   = rst_i ? '0 : gnt;
    assign granted = any & ~rst_i;
    assign rdata_o = (|rvalid_o) ? mem_data_i : '0;

    always_comb begin
        state_n = state;
        owner_n = owner;
        ptr_n   = ptr;
        unique case (state)
            ARB: begin
                if (any) begin
                    ptr_n = next_idx(win);
                    if (lock_i[win]) begin
                        state_n = LOCKED;
                        owner_n = win;
                    end
                end
            end
            LOCKED: begin
                // The releasing cycle's access was already granted above.
                if (!req_i[owner] || !lock_i[owner]) begin
                    state_n = ARB;
                    ptr_n   = next_idx(owner);
                end
            end
            default: state_n = ARB;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ARB;
            ptr        <= '0;
            owner      <= '0;
            rd_pend    <= 1'b0;
            rd_idx     <= '0;
            rvalid_o   <= '0;
            mem_cenb_o <= 1'b1;
            mem_wenb_o <= 1'b1;
            mem_addr_o <= '0;
            mem_data_o <= '0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            owner    <= owner_n;
            rd_pend  <= granted & ~we_i[win];
            rd_idx   <= win;
            rvalid_o <= rv_n;
            if (granted) begin
                mem_cenb_o <= 1'b0;
                mem_wenb_o <= ~we_i[win];
                mem_addr_o <= addr_i[win*AW +: AW];
                mem_data_o <= wdata_i[win*DW +: DW];
            end else begin
                mem_cenb_o <= 1'b1;
                mem_wenb_o <= 1'b1;
            end
        end
    end

endmodule
